// File: rtl/rate_detector.sv
// Measures the spacing of a single-cycle tick stream and decodes it back to the
// 2-bit rate code that produced it, with lock, mismatch and timeout reporting.
module rate_detector #(
  parameter int CW  = 28,
  parameter int P0  = 3,
  parameter int P1  = 50_000_000,
  parameter int P2  = 100_000_000,
  parameter int P3  = 200_000_000,
  parameter int TOL = 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          tick,
  output logic [1:0]    rate,
  output logic          valid,
  output logic [CW-1:0] period,
  output logic          err
);

  localparam int            TIMEOUT_I = P3 + TOL + 1;
  localparam logic [CW-1:0] TIMEOUT   = CW'(TIMEOUT_I);
  localparam int            PK [4]    = '{P0, P1, P2, P3};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_LOCKED
  } state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_cand, w_cand_next;
  logic [1:0]    r_rate, w_rate_next;
  logic          r_valid, w_valid_next;
  logic [CW-1:0] r_period, w_period_next;
  logic          r_err, w_err_next;
  logic [CW-1:0] r_elapsed, w_elapsed_next;

  logic [3:0]    w_match;
  logic          w_hit;
  logic [1:0]    w_code;
  logic          w_timeout;

  // Elapsed equals the tick-to-tick period on the edge that samples the tick.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
      localparam int            LO_I = (PK[gi] > TOL) ? PK[gi] - TOL : 0;
      localparam logic [CW-1:0] LO   = CW'(LO_I);
      localparam logic [CW-1:0] HI   = CW'(PK[gi] + TOL);
      assign w_match[gi] = (r_elapsed >= LO) && (r_elapsed <= HI);
    end
  endgenerate

  always_comb begin
    w_hit  = 1'b0;
    w_code = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_match[k]) begin
        w_hit  = 1'b1;
        w_code = 2'(k);
      end
    end
  end

  assign w_timeout = (r_elapsed == TIMEOUT);

  always_comb begin
    w_elapsed_next = tick ? CW'(1) : (w_timeout ? r_elapsed : r_elapsed + CW'(1));
  end

  always_comb begin
    w_state_next  = r_state;
    w_cand_next   = r_cand;
    w_rate_next   = r_rate;
    w_valid_next  = r_valid;
    w_period_next = r_period;
    w_err_next    = 1'b0;
    if (tick) begin
      if (r_state == S_IDLE) begin
        w_state_next = S_ARMED;
      end else begin
        w_period_next = r_elapsed;
        case (r_state)
          S_ARMED: begin
            if (w_hit) begin
              w_cand_next  = w_code;
              w_state_next = S_CHECK;
            end else begin
              w_err_next = 1'b1;
            end
          end
          S_CHECK: begin
            if (w_hit && w_code == r_cand) begin
              w_state_next = S_LOCKED;
              w_rate_next  = r_cand;
              w_valid_next = 1'b1;
            end else if (w_hit) begin
              w_cand_next = w_code;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = S_ARMED;
            end
          end
          S_LOCKED: begin
            if (!(w_hit && w_code == r_rate)) begin
              w_valid_next = 1'b0;
              w_err_next   = 1'b1;
              if (w_hit) begin
                w_cand_next  = w_code;
                w_state_next = S_CHECK;
              end else begin
                w_state_next = S_ARMED;
              end
            end
          end
          default: w_state_next = S_IDLE;
        endcase
      end
    end else if (r_state != S_IDLE && w_timeout) begin
      w_state_next = S_IDLE;
      w_valid_next = 1'b0;
      w_err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_cand    <= 2'd0;
      r_rate    <= 2'd0;
      r_valid   <= 1'b0;
      r_period  <= '0;
      r_err     <= 1'b0;
      r_elapsed <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cand    <= w_cand_next;
      r_rate    <= w_rate_next;
      r_valid   <= w_valid_next;
      r_period  <= w_period_next;
      r_err     <= w_err_next;
      r_elapsed <= w_elapsed_next;
    end
  end

  assign rate   = r_rate;
  assign valid  = r_valid;
  assign period = r_period;
  assign err    = r_err;

endmodule

// File: tb/tb_rate_detector.sv
// Bench for rate_detector: directed scenarios then random tick spacing, every
// cycle compared against a timestamp-based reference model.
module tb_rate_detector;

  localparam int CW      = 28;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 42;

  logic          clk;
  logic          clear;
  logic          tick;
  logic [1:0]    rate;
  logic          valid;
  logic [CW-1:0] period;
  logic          err;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 waiting first period, 2 candidate seen, 3 locked.
  int m_mode, m_cand, m_rate, m_valid, m_period, m_err;
  int cyc, m_last;

  rate_detector #(
    .CW(CW), .P0(3), .P1(10), .P2(20), .P3(40), .TOL(TOL)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .tick  (tick),
    .rate  (rate),
    .valid (valid),
    .period(period),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classify(input int p);
    int pk [4];
    int d;
    pk = '{3, 10, 20, 40};
    for (int k = 0; k < 4; k++) begin
      d = (p > pk[k]) ? p - pk[k] : pk[k] - p;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cand = 0; m_rate = 0; m_valid = 0; m_period = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic t);
    int gap, p, k;
    cyc++;
    gap = cyc - m_last;
    m_err = 0;
    if (t) begin
      if (m_mode != 0) begin
        p = (gap > TIMEOUT) ? TIMEOUT : gap;
        m_period = p;
        k = classify(p);
        if (m_mode == 1) begin
          if (k >= 0) begin m_cand = k; m_mode = 2; end
          else m_err = 1;
        end else if (m_mode == 2) begin
          if (k >= 0 && k == m_cand) begin m_mode = 3; m_rate = k; m_valid = 1; end
          else if (k >= 0) m_cand = k;
          else begin m_err = 1; m_mode = 1; end
        end else if (k != m_rate) begin
          m_valid = 0;
          m_err   = 1;
          if (k >= 0) begin m_cand = k; m_mode = 2; end
          else m_mode = 1;
        end
      end else begin
        m_mode = 1;
      end
      m_last = cyc;
    end else if (m_mode != 0 && gap == TIMEOUT) begin
      m_mode  = 0;
      m_valid = 0;
      m_err   = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic t);
    tick = t;
    @(posedge clk);
    model_edge(t);
    #1;
    chk("m_rate",   32'(rate),   32'(m_rate));
    chk("m_valid",  32'(valid),  32'(m_valid));
    chk("m_period", 32'(period), 32'(m_period));
    chk("m_err",    32'(err),    32'(m_err));
  endtask

  task automatic send(input int per);
    repeat (per - 1) cycle(1'b0);
    cycle(1'b1);
    $display("tick gap=%0d rate=%0d valid=%0d period=%0d err=%0d",
             per, rate, valid, period, err);
  endtask

  initial begin
    int per, reps;
    int ptab [20];
    ptab = '{1, 2, 3, 4, 5, 9, 10, 11, 12, 19, 20, 21, 22, 30, 39, 40, 41, 42, 43, 50};
    clear = 1'b1;
    tick  = 1'b0;
    cyc   = 0;
    m_last = 0;
    model_reset();
    #2;
    chk("rst_rate", 32'(rate), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_err", 32'(err), 0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;

    // 1: lock to code 00
    cycle(1'b1);
    send(3);
    send(3);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_rate", 32'(rate), 0);
    chk("t1_period", 32'(period), 3);
    chk("t1_err", 32'(err), 0);

    // 2: lock at 10, switch to 20
    send(10); send(10); send(10);
    chk("t2_lock01", 32'(valid), 1);
    send(20);
    chk("t2_valid0", 32'(valid), 0);
    chk("t2_err", 32'(err), 1);
    chk("t2_period", 32'(period), 20);
    send(20);
    chk("t2_valid1", 32'(valid), 1);
    chk("t2_rate", 32'(rate), 2);

    // 3: jitter inside the window, then outside
    send(19); chk("t3_v19", 32'(valid), 1); chk("t3_e19", 32'(err), 0);
    send(21); chk("t3_v21", 32'(valid), 1); chk("t3_e21", 32'(err), 0);
    send(20); chk("t3_v20", 32'(valid), 1); chk("t3_e20", 32'(err), 0);
    send(22); chk("t3_e22", 32'(err), 1); chk("t3_v22", 32'(valid), 0);
    send(20); chk("t3_check", 32'(valid), 0);
    send(20); chk("t3_relock", 32'(valid), 1); chk("t3_rate", 32'(rate), 2);

    // 4: lock at 40 then stop ticking
    send(40); send(40);
    chk("t4_lock", 32'(valid), 1);
    chk("t4_rate", 32'(rate), 3);
    repeat (TIMEOUT - 1) cycle(1'b0);
    chk("t4_pre_valid", 32'(valid), 1);
    chk("t4_pre_err", 32'(err), 0);
    cycle(1'b0);
    chk("t4_to_valid", 32'(valid), 0);
    chk("t4_to_err", 32'(err), 1);
    chk("t4_to_period", 32'(period), 40);
    cycle(1'b0);
    chk("t4_err_once", 32'(err), 0);
    cycle(1'b1);
    chk("t4_idle_tick", 32'(err), 0);
    repeat (TIMEOUT) cycle(1'b0);
    chk("t4_armed_to", 32'(err), 1);

    // 6: tick held high three cycles from idle
    cycle(1'b1); chk("t6_e1", 32'(err), 0);
    cycle(1'b1); chk("t6_e2", 32'(err), 1); chk("t6_p2", 32'(period), 1);
    cycle(1'b1); chk("t6_e3", 32'(err), 1); chk("t6_v3", 32'(valid), 0);
    cycle(1'b0); chk("t6_e4", 32'(err), 0);

    // 5: asynchronous clear while locked
    send(10); send(10);
    chk("t5_lock", 32'(valid), 1);
    chk("t5_rate", 32'(rate), 1);
    clear = 1'b1;
    #2;
    chk("t5_clr_valid", 32'(valid), 0);
    chk("t5_clr_rate", 32'(rate), 0);
    chk("t5_clr_period", 32'(period), 0);
    chk("t5_clr_err", 32'(err), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    cycle(1'b1);
    send(10);
    send(10);
    chk("t5_relock", 32'(valid), 1);
    chk("t5_rerate", 32'(rate), 1);

    // random spacing, each period repeated a few times so locks occur
    for (int i = 0; i < 300; i++) begin
      per  = ptab[$urandom_range(0, 19)];
      reps = $urandom_range(1, 4);
      for (int r = 0; r < reps; r++) send(per);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_detector.md
# rate_detector

Measures the spacing of a single-cycle `tick` pulse stream in `clk` cycles and decodes it back to the 2-bit rate code (00/01/10/11) that produced it. It is the receive-side counterpart of the rate-select enable generator. Typical uses are confirming that a counter stage is running at the selected rate, or recovering the rate code from an enable line alone. Results are registered: `rate`, `valid`, `period` and `err`.

## Interface
- `CW`, 28: counter and period width.
- `P0`, 3: expected tick period in cycles for code 00.
- `P1`, 50_000_000: expected period for code 01 (1 Hz).
- `P2`, 100_000_000: expected period for code 10 (0.5 Hz).
- `P3`, 200_000_000: expected period for code 11 (0.25 Hz).
- `TOL`, 1: accepted deviation in cycles, ± from each Pk.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  enable pulse being measured; every cycle that is high counts as one tick.
- `rate`  out  2  decoded rate code; meaningful only while `valid`=1.
- `valid`  out  1  high while locked to a code.
- `period`  out  CW  last measured tick-to-tick period.
- `err`  out  1  one-cycle pulse on a mismatch or a timeout.

## Operation
- **Period definition:** for consecutive ticks sampled at edges t0 and t1, period = t1 − t0.
- **Elapsed counter:**
  - Set to 1 on the cycle after each tick.
  - Increments by 1 each cycle.
  - Saturates at TIMEOUT = P3+TOL+1.
- **Classification:** the period matches code k when |period − Pk| ≤ TOL. If tolerance windows overlap, the lowest k wins. Any other period is "no match".
- **IDLE** (reset state):
  - tick → ARMED.
  - No error is ever raised from IDLE.
- **ARMED:**
  - tick with match k → store cand=k, go to CHECK.
  - tick with no match → `err` pulse, stay in ARMED (the measurement restarts).
- **CHECK:**
  - tick matching cand → LOCKED, `rate`=cand, `valid`=1.
  - tick matching a different k → cand=k, stay in CHECK.
  - tick with no match → `err` pulse, go to ARMED.
- **LOCKED:**
  - tick matching `rate` → stay in LOCKED.
  - tick matching a different k → `valid`=0, `err` pulse, cand=k, go to CHECK.
  - tick with no match → `valid`=0, `err` pulse, go to ARMED.
- **Timeout:** in ARMED, CHECK or LOCKED, if elapsed reaches TIMEOUT with no tick that cycle → IDLE, `valid`=0, `err` pulse.
- **Simultaneous tick and timeout:** the tick wins. Its period is TIMEOUT, which is no match → `err` pulse, go to ARMED.
- **`period` output:** updated on every tick seen in ARMED, CHECK or LOCKED. It holds its value otherwise, including through a timeout.
- **`rate` output:** holds its last locked value while `valid`=0.
- **Width rule:** CW must hold TIMEOUT. The defaults give 200_000_002 < 2^28.

## Timing
- **Reset values:** `rate`=0, `valid`=0, `period`=0, `err`=0, state IDLE, elapsed=0.
- **Reset assertion:** takes effect immediately, without waiting for a clock edge.
- **Reset release:** the first edge after `clear` falls is a normal edge.
- **Output latency:** the edge that samples `tick`=1 updates state and all outputs, which are visible in the following cycle. There is no combinational path from `tick` to any output.
- **Lock latency:** from IDLE, `valid` rises one cycle after the third consecutive tick of a matching rate, i.e. two matching periods.
- **Error pulse:** `err` is high for exactly one cycle per event and is never held.
- **Tick held high N cycles:** gives periods of 1. Each is no match unless 1 falls within a window, so `err` pulses once per cycle after the first.

## Test plan
Benches override the parameters to P0=3, P1=10, P2=20, P3=40, TOL=1, which gives TIMEOUT=42.

1. Release `clear`, then drive ticks every 3 cycles → `valid`=1, `rate`=00 and `period`=3 in the cycle after the 3rd tick, with no `err`.
2. Lock at period 10, then switch to period 20 → at the first 20-period tick: `valid`=0, `err` pulses once, `period`=20. At the next 20-period tick: `valid`=1, `rate`=10.
3. While locked at 20, drive periods 19, 21, 20 → `valid` stays 1 and `err` stays 0. Then drive period 22 → `err` pulses, `valid`=0, state is ARMED (a following 20, 20 relocks after two ticks).
4. Lock at 40, then stop ticks → exactly 42 cycles after the last tick: `valid` falls, `err` pulses once, `period` stays 40. The next tick raises no `err` because the block is in IDLE.
5. Assert `clear` between clock edges while locked → `valid`, `rate`, `period` and `err` read 0 before the next edge. Ticks every 10 after release → lock to 01 after the 3rd tick.
6. Hold `tick` high for 3 cycles from IDLE → `err` pulses on the 2nd and 3rd tick edges (period 1), and `valid` stays 0.
